// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register file write port, with hazard lookup.
// Optional WBQ_BYPASS_EN adds youngest-match forwarding ports out_fwd_A/B.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          in_clk,
  input  logic          in_rst_n,
  input  logic          in_wb_valid,
  output logic          out_wb_ready,
  input  logic [31:0]   in_wb_data,
  input  logic [4:0]    in_wb_dest,
  input  logic          in_stall,
  output logic [31:0]   out_PC,
  output logic [4:0]    out_SC,
  output logic          out_RFL,
  input  logic [4:0]    in_SA,
  input  logic [4:0]    in_SB,
  output logic          out_pend_A,
  output logic          out_pend_B,
  output logic [AW:0]   out_count,
  output logic          out_empty,
`ifdef WBQ_BYPASS_EN
  output logic [31:0]   out_fwd_A,
  output logic [31:0]   out_fwd_B,
`endif
  output logic          out_full
);

  logic [31:0]      data_q [DEPTH];
  logic [4:0]       dest_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic             push_hs, push, pop;

  assign out_empty    = (count_q == '0);
  assign out_full     = (count_q == (AW+1)'(DEPTH));
  assign out_wb_ready = !out_full;
  assign out_count    = count_q;

  // R0 writes complete the handshake but never occupy a slot
  assign push_hs = in_wb_valid && out_wb_ready;
  assign push    = push_hs && (in_wb_dest != 5'd0);
  assign pop     = out_RFL;

  assign out_RFL = !out_empty && !in_stall;
  assign out_PC  = out_empty ? 32'd0 : data_q[head_q];
  assign out_SC  = out_empty ? 5'd0  : dest_q[head_q];

  // Next-state for pointers, count and per-entry valid bits
  always_comb begin
    head_d  = pop  ? head_q + AW'(1) : head_q;
    tail_d  = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    valid_d = valid_q;
    if (pop)  valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
  end

  // Queue state and entry storage
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      if (push) begin
        data_q[tail_q] <= in_wb_data;
        dest_q[tail_q] <= in_wb_dest;
      end
    end
  end

  // Pending lookup; an entry popping this edge still counts
  always_comb begin
    out_pend_A = 1'b0;
    out_pend_B = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && dest_q[i] == in_SA) out_pend_A = 1'b1;
      if (valid_q[i] && dest_q[i] == in_SB) out_pend_B = 1'b1;
    end
    if (in_SA == 5'd0) out_pend_A = 1'b0;
    if (in_SB == 5'd0) out_pend_B = 1'b0;
  end

`ifdef WBQ_BYPASS_EN
  logic [AW-1:0] byp_idx;

  // Walk oldest to youngest from head so the youngest match wins
  always_comb begin
    out_fwd_A = 32'd0;
    out_fwd_B = 32'd0;
    byp_idx   = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      byp_idx = head_q + AW'(k);
      if (valid_q[byp_idx] && in_SA != 5'd0 &&
          dest_q[byp_idx] == in_SA)
        out_fwd_A = data_q[byp_idx];
      if (valid_q[byp_idx] && in_SB != 5'd0 &&
          dest_q[byp_idx] == in_SB)
        out_fwd_B = data_q[byp_idx];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue.
// Models the register file from the write port and checks fixed vectors.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        stall;
  logic [31:0] pc;
  logic [4:0]  sc;
  logic        rfl;
  logic [4:0]  sa, sb;
  logic        pend_a, pend_b;
  logic [AW:0] count;
  logic        empty, full;
`ifdef WBQ_BYPASS_EN
  logic [31:0] fwd_a, fwd_b;
`endif

  int checks = 0;
  int errors = 0;
  int nwr = 0;
  logic [31:0] rf [32];

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .in_clk(clk),
    .in_rst_n(rst_n),
    .in_wb_valid(wb_valid),
    .out_wb_ready(wb_ready),
    .in_wb_data(wb_data),
    .in_wb_dest(wb_dest),
    .in_stall(stall),
    .out_PC(pc),
    .out_SC(sc),
    .out_RFL(rfl),
    .in_SA(sa),
    .in_SB(sb),
    .out_pend_A(pend_a),
    .out_pend_B(pend_b),
    .out_count(count),
    .out_empty(empty),
`ifdef WBQ_BYPASS_EN
    .out_fwd_A(fwd_a),
    .out_fwd_B(fwd_b),
`endif
    .out_full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rfl) begin
      rf[sc] <= pc;
      nwr <= nwr + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_valid = 1'b0; wb_data = '0; wb_dest = '0;
    stall = 1'b0; sa = '0; sb = '0;
    #12;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", wb_ready); end
    checks++; if (rfl !== 1'b0) begin errors++; $display("FAIL rst_rfl got %b exp 0", rfl); end
    checks++; if (pc !== 32'd0 || sc !== 5'd0) begin errors++; $display("FAIL rst_port got %h/%0d exp 0/0", pc, sc); end
    checks++; if (pend_a !== 1'b0 || pend_b !== 1'b0) begin errors++; $display("FAIL rst_pend got %b%b exp 00", pend_a, pend_b); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    stall = 1'b0; sa = 5'd4;
    wb_valid = 1'b1; wb_dest = 5'd4; wb_data = 32'h4;
    step();
    wb_valid = 1'b0;
    #1;
    checks++; if (rfl !== 1'b1) begin errors++; $display("FAIL single_rfl got %b exp 1", rfl); end
    checks++; if (sc !== 5'd4) begin errors++; $display("FAIL single_sc got %0d exp 4", sc); end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL single_pc got %h exp 4", pc); end
    checks++; if (pend_a !== 1'b1) begin errors++; $display("FAIL single_pend got %b exp 1", pend_a); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b exp 1", empty); end
    checks++; if (rf[4] !== 32'h4) begin errors++; $display("FAIL single_rf4 got %h exp 4", rf[4]); end
    checks++; if (pend_a !== 1'b0) begin errors++; $display("FAIL single_pend_clr got %b exp 0", pend_a); end
    sa = 5'd0;
  endtask

  task automatic test_full();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1;
      wb_dest = (i == 3) ? 5'd5 : 5'(i + 1);
      wb_data = 32'hA + 32'(i);
      step();
    end
    wb_dest = 5'd6; wb_data = 32'h66;
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
    checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", wb_ready); end
    checks++; if (rfl !== 1'b0) begin errors++; $display("FAIL full_stall_rfl got %b exp 0", rfl); end
    step();
    wb_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject got %0d exp 4", count); end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (rfl !== 1'b1 || sc !== ((i == 3) ? 5'd5 : 5'(i + 1)) || pc !== 32'hA + 32'(i)) begin
        errors++; $display("FAIL full_drain%0d got %b/%0d/%h exp 1/%0d/%h", i, rfl, sc, pc, (i == 3) ? 5 : i + 1, 32'hA + 32'(i));
      end
      step();
      if (i == 0) begin
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %b exp 1", wb_ready); end
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty got %b exp 1", empty); end
    checks++; if (rf[5] !== 32'hD) begin errors++; $display("FAIL full_rf5 got %h exp d", rf[5]); end
  endtask

  task automatic test_r0();
    int n0;
    n0 = nwr;
    sa = 5'd0;
    wb_valid = 1'b1; wb_dest = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b exp 1", wb_ready); end
    step();
    wb_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL r0_count got %0d exp 0", count); end
    checks++; if (rfl !== 1'b0) begin errors++; $display("FAIL r0_rfl got %b exp 0", rfl); end
    checks++; if (pend_a !== 1'b0) begin errors++; $display("FAIL r0_pend got %b exp 0", pend_a); end
    step();
    checks++; if (nwr !== n0) begin errors++; $display("FAIL r0_writes got %0d exp %0d", nwr, n0); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_dest = 5'(7 + i); wb_data = 32'(7 + i);
      step();
    end
    wb_valid = 1'b0;
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_pre_empty got %b exp 1", empty); end
    stall = 1'b1;
    wb_valid = 1'b1; wb_dest = 5'd3; wb_data = 32'h1;
    step();
    wb_data = 32'hFFFF_FFFF;
    step();
    wb_valid = 1'b0; sb = 5'd3;
    #1;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL wrap_count got %0d exp 2", count); end
    checks++; if (pend_b !== 1'b1) begin errors++; $display("FAIL wrap_pend_b got %b exp 1", pend_b); end
`ifdef WBQ_BYPASS_EN
    checks++; if (fwd_b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_fwd_b got %h exp ffffffff", fwd_b); end
    checks++; if (fwd_a !== 32'h0) begin errors++; $display("FAIL wrap_fwd_a got %h exp 0", fwd_a); end
`endif
    stall = 1'b0;
    #1;
    checks++; if (rfl !== 1'b1 || sc !== 5'd3 || pc !== 32'h1) begin errors++; $display("FAIL wrap_first got %b/%0d/%h exp 1/3/1", rfl, sc, pc); end
    step();
`ifdef WBQ_BYPASS_EN
    checks++; if (fwd_b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_fwd_b2 got %h exp ffffffff", fwd_b); end
`endif
    checks++; if (rfl !== 1'b1 || sc !== 5'd3 || pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_second got %b/%0d/%h exp 1/3/ffffffff", rfl, sc, pc); end
    step();
    checks++; if (rf[3] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_rf3 got %h exp ffffffff", rf[3]); end
    checks++; if (empty !== 1'b1 || pend_b !== 1'b0) begin errors++; $display("FAIL wrap_end got %b/%b exp 1/0", empty, pend_b); end
    sb = 5'd0;
  endtask

  task automatic test_back_to_back();
    int n0;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wb_valid = 1'b1; wb_dest = 5'(10 + i); wb_data = 32'h100 + 32'(10 + i);
      step();
    end
    n0 = nwr;
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wb_valid = 1'b1; wb_dest = 5'(12 + i); wb_data = 32'h100 + 32'(12 + i);
      #1;
      checks++; if (rfl !== 1'b1 || sc !== 5'(10 + i) || pc !== 32'h100 + 32'(10 + i) || count !== 3'd2) begin
        errors++; $display("FAIL b2b_%0d got %b/%0d/%h/%0d exp 1/%0d/%h/2", i, rfl, sc, pc, count, 10 + i, 32'h100 + 32'(10 + i));
      end
      step();
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (rfl !== 1'b1 || sc !== 5'(16 + i) || pc !== 32'h100 + 32'(16 + i)) begin
        errors++; $display("FAIL b2b_tail%0d got %b/%0d/%h exp 1/%0d/%h", i, rfl, sc, pc, 16 + i, 32'h100 + 32'(16 + i));
      end
      step();
    end
    checks++; if (nwr !== n0 + 8) begin errors++; $display("FAIL b2b_writes got %0d exp %0d", nwr, n0 + 8); end
    checks++; if (empty !== 1'b1 || rf[17] !== 32'h111) begin errors++; $display("FAIL b2b_end got %b/%h exp 1/111", empty, rf[17]); end
  endtask

  task automatic test_reset_mid();
    int n0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_dest = 5'(20 + i); wb_data = 32'(20 + i);
      step();
    end
    wb_valid = 1'b0; stall = 1'b0;
    n0 = nwr;
    rst_n = 1'b0;
    #1;
    checks++; if (rfl !== 1'b0) begin errors++; $display("FAIL rmid_rfl got %b exp 0", rfl); end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL rmid_state got %0d/%b exp 0/1", count, empty); end
    step();
    rst_n = 1'b1;
    step(); step(); step();
    checks++; if (nwr !== n0) begin errors++; $display("FAIL rmid_writes got %0d exp %0d", nwr, n0); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b exp 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_r0();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
